// File: rtl/cv32e41p_hwloop_bank.sv
// Hardware-loop register bank: start/end addresses and iteration counters for N_REGS loops.
// Optional misuse detection is built when CV32E41P_HWLOOP_ERR_EN is defined.
module cv32e41p_hwloop_bank #(
   parameter int N_REGS     = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [ADDR_WIDTH-1:0]                 hwlp_start_data_i,
   input  logic [ADDR_WIDTH-1:0]                 hwlp_end_data_i,
   input  logic [CNT_WIDTH-1:0]                  hwlp_cnt_data_i,
   input  logic [2:0]                            hwlp_we_i,
   input  logic [N_REG_BITS-1:0]                 hwlp_regid_i,
   input  logic                                  valid_i,
   input  logic [N_REGS-1:0]                     hwlp_dec_cnt_i,
   input  logic                                  hwlp_flush_i,
   output logic [N_REGS-1:0][ADDR_WIDTH-1:0]     hwlp_start_addr_o,
   output logic [N_REGS-1:0][ADDR_WIDTH-1:0]     hwlp_end_addr_o,
   output logic [N_REGS-1:0][CNT_WIDTH-1:0]      hwlp_counter_o,
   output logic [N_REGS-1:0]                     hwlp_active_o,
   output logic [N_REGS-1:0]                     hwlp_last_o,
   output logic [N_REGS-1:0]                     hwlp_done_o,
   output logic                                  hwlp_err_o
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

   state_e                state_q [N_REGS];
   logic [ADDR_WIDTH-1:1] start_q [N_REGS];
   logic [ADDR_WIDTH-1:1] end_q   [N_REGS];
   logic [CNT_WIDTH-1:0]  cnt_q   [N_REGS];
   logic [N_REGS-1:0]     done_q;

   logic                  regid_ok;
   logic [N_REGS-1:0]     wsel;
   logic [N_REGS-1:0]     cnt_write;
   logic [N_REGS-1:0]     dec_grant;
   logic [N_REGS-1:0]     cnt_nz;
   logic                  found;
   logic                  unused_addr_lsb;

   // Address bit 0 is never stored: loop bodies are halfword aligned.
   assign unused_addr_lsb = hwlp_start_data_i[0] ^ hwlp_end_data_i[0];

   assign regid_ok = {1'b0, hwlp_regid_i} < (N_REG_BITS+1)'(N_REGS);

   always_comb begin
      wsel      = '0;
      cnt_write = '0;
      dec_grant = '0;
      cnt_nz    = '0;
      found     = 1'b0;
      for (int k = 0; k < N_REGS; k++) begin
         wsel[k]      = regid_ok && (hwlp_regid_i == N_REG_BITS'(k));
         cnt_write[k] = wsel[k] && hwlp_we_i[2];
         cnt_nz[k]    = (cnt_q[k] != '0);
         // Only the lowest requesting loop may step per retired instruction.
         if (valid_i && hwlp_dec_cnt_i[k] && !found) begin
            dec_grant[k] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_REGS; k++) begin
            state_q[k] <= IDLE;
            start_q[k] <= '0;
            end_q[k]   <= '0;
            cnt_q[k]   <= '0;
         end
         done_q <= '0;
      end else begin
         for (int k = 0; k < N_REGS; k++) begin
            done_q[k] <= 1'b0;
            if (wsel[k] && hwlp_we_i[0]) start_q[k] <= hwlp_start_data_i[ADDR_WIDTH-1:1];
            if (wsel[k] && hwlp_we_i[1]) end_q[k]   <= hwlp_end_data_i[ADDR_WIDTH-1:1];
            if (hwlp_flush_i) begin
               cnt_q[k]   <= '0;
               state_q[k] <= IDLE;
            end else if (cnt_write[k]) begin
               cnt_q[k]   <= hwlp_cnt_data_i;
               state_q[k] <= (hwlp_cnt_data_i != '0) ? ACTIVE : IDLE;
            end else if (dec_grant[k] && cnt_nz[k]) begin
               cnt_q[k] <= cnt_q[k] - CNT_WIDTH'(1);
               if (cnt_q[k] == CNT_WIDTH'(1)) begin
                  state_q[k] <= IDLE;
                  done_q[k]  <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N_REGS; k++) begin
         hwlp_start_addr_o[k] = {start_q[k], 1'b0};
         hwlp_end_addr_o[k]   = {end_q[k], 1'b0};
         hwlp_counter_o[k]    = cnt_q[k];
         hwlp_active_o[k]     = (state_q[k] == ACTIVE);
         hwlp_last_o[k]       = (cnt_q[k] == CNT_WIDTH'(1));
      end
   end

   assign hwlp_done_o = done_q;

`ifdef CV32E41P_HWLOOP_ERR_EN
   logic err_q;
   logic dec_multi;
   logic underflow;
   logic bad_regid;

   assign dec_multi = valid_i && ((hwlp_dec_cnt_i & (hwlp_dec_cnt_i - N_REGS'(1))) != '0);
   // A counter write to the same loop overrides the decrement, so it is not an underflow.
   assign underflow = |(dec_grant & ~cnt_nz & ~cnt_write);
   assign bad_regid = (hwlp_we_i != 3'b000) && !regid_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            err_q <= 1'b0;
      else if (hwlp_flush_i) err_q <= 1'b0;
      else if (dec_multi || underflow || bad_regid) err_q <= 1'b1;
   end

   assign hwlp_err_o = err_q;
`else
   assign hwlp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e41p_hwloop_bank.sv
// Scoreboard bench for cv32e41p_hwloop_bank (3 loops, 16-bit addresses, 8-bit counters).
module tb_cv32e41p_hwloop_bank;
   localparam int N  = 3;
   localparam int AW = 16;
   localparam int CW = 8;
   localparam int RB = 2;
`ifdef CV32E41P_HWLOOP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [N-1:0][AW-1:0] start;
      logic [N-1:0][AW-1:0] fin;
      logic [N-1:0][CW-1:0] cnt;
      logic [N-1:0]         active;
      logic [N-1:0]         last;
      logic [N-1:0]         done;
      logic                 err;
   } exp_t;
   localparam int W = $bits(exp_t);

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]        start_d, end_d;
   logic [CW-1:0]        cnt_d;
   logic [2:0]           we;
   logic [RB-1:0]        regid;
   logic                 valid;
   logic [N-1:0]         dec;
   logic                 flush;
   logic [N-1:0][AW-1:0] start_o, end_o;
   logic [N-1:0][CW-1:0] cnt_o;
   logic [N-1:0]         active_o, last_o, done_o;
   logic                 err_o;

   cv32e41p_hwloop_bank #(.N_REGS(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .N_REG_BITS(RB)) dut (
      .clk(clk), .rst_n(rst_n),
      .hwlp_start_data_i(start_d), .hwlp_end_data_i(end_d), .hwlp_cnt_data_i(cnt_d),
      .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid), .hwlp_dec_cnt_i(dec),
      .hwlp_flush_i(flush),
      .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o), .hwlp_counter_o(cnt_o),
      .hwlp_active_o(active_o), .hwlp_last_o(last_o), .hwlp_done_o(done_o), .hwlp_err_o(err_o)
   );

   // reference model state
   int unsigned m_start [N];
   int unsigned m_end   [N];
   int unsigned m_cnt   [N];
   bit          m_err;
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_start[k] = 0; m_end[k] = 0; m_cnt[k] = 0;
      end
      m_err = 1'b0;
   endtask

   function automatic exp_t model_view(input logic [N-1:0] done);
      exp_t e;
      for (int k = 0; k < N; k++) begin
         e.start[k]  = AW'(m_start[k]);
         e.fin[k]    = AW'(m_end[k]);
         e.cnt[k]    = CW'(m_cnt[k]);
         e.active[k] = (m_cnt[k] != 0);
         e.last[k]   = (m_cnt[k] == 1);
      end
      e.done = done;
      e.err  = m_err;
      return e;
   endfunction

   // Apply one cycle of the loop-bank rules to the model using the current inputs.
   task automatic model_step();
      logic [N-1:0] done = '0;
      bit flag = 1'b0;
      int grant = -1;
      int ones = 0;
      bool_regid: begin end
      if (we != 0 && regid >= N) flag = 1'b1;
      if (valid) begin
         for (int k = N - 1; k >= 0; k--) if (dec[k]) begin grant = k; ones++; end
         if (ones > 1) flag = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
         bit sel = (regid == k);
         if (sel && we[0]) m_start[k] = start_d & ~32'h1;
         if (sel && we[1]) m_end[k]   = end_d & ~32'h1;
         if (flush) m_cnt[k] = 0;
         else if (sel && we[2]) m_cnt[k] = cnt_d;
         else if (k == grant) begin
            if (m_cnt[k] == 0) flag = 1'b1;
            else begin
               if (m_cnt[k] == 1) done[k] = 1'b1;
               m_cnt[k] = m_cnt[k] - 1;
            end
         end
      end
      if (flush) m_err = 1'b0;
      else if (flag && ERR_EN) m_err = 1'b1;
      exp_q.push_back(W'(model_view(done)));
   endtask

   // driver: inputs are set by the caller just after a negedge
   task automatic cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start_d = '0; end_d = '0; cnt_d = '0; we = '0; regid = '0;
      valid = 1'b0; dec = '0; flush = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin idle_inputs(); cycle(); end
   endtask

   task automatic write_loop(input int r, input logic [2:0] w, input int s, input int e, input int c);
      idle_inputs();
      regid = RB'(r); we = w; start_d = AW'(s); end_d = AW'(e); cnt_d = CW'(c);
      cycle();
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #3;
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic compare(input exp_t e);
      chk("start_addr", 64'(start_o), 64'(e.start));
      chk("end_addr",   64'(end_o),   64'(e.fin));
      chk("counter",    64'(cnt_o),   64'(e.cnt));
      chk("active",     64'(active_o), 64'(e.active));
      chk("last",       64'(last_o),  64'(e.last));
      chk("done",       64'(done_o),  64'(e.done));
      chk("err",        64'(err_o),   64'(e.err));
   endtask

   // monitor: outputs are valid every cycle; compare shortly after each active edge
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) compare(exp_t'(exp_q.pop_front()));
      end
   end

   initial begin
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare(model_view('0));
      @(negedge clk);
      rst_n = 1'b1;

      // program loop 1 and count it down
      write_loop(1, 3'b111, 'h100, 'h11F, 3);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         idle_inputs(); valid = 1'b1; dec = 3'b010; cycle();
      end
      idle(2);

      // counter write and decrement to the same loop in one cycle
      idle_inputs(); regid = 2'd1; we = 3'b100; cnt_d = 8'd5; valid = 1'b1; dec = 3'b010; cycle();
      idle(2);

      // two simultaneous decrement requests
      write_loop(0, 3'b100, 0, 0, 4);
      write_loop(1, 3'b100, 0, 0, 4);
      idle_inputs(); valid = 1'b1; dec = 3'b011; cycle();
      idle(1);
      idle_inputs(); flush = 1'b1; cycle();
      idle(1);

      // underflow, then out-of-range regid, then flush
      idle_inputs(); valid = 1'b1; dec = 3'b100; cycle();
      idle(1);
      write_loop(3, 3'b001, 'hBEEF, 'h1234, 7);
      idle(1);
      idle_inputs(); flush = 1'b1; cycle();
      idle(1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         if ($urandom_range(0, 9) < 3) begin
            we = 3'($urandom_range(1, 7));
            regid = RB'($urandom_range(0, 3));
            start_d = AW'($urandom); end_d = AW'($urandom);
            cnt_d = CW'($urandom_range(0, 6));
         end
         valid = 1'($urandom_range(0, 1));
         dec   = N'($urandom_range(0, 7));
         flush = ($urandom_range(0, 29) == 0);
         cycle();
      end
      idle(2);

      // reset during a countdown
      write_loop(0, 3'b111, 'h200, 'h240, 10);
      for (int i = 0; i < 3; i++) begin
         idle_inputs(); valid = 1'b1; dec = 3'b001; cycle();
      end
      drain();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare(model_view('0));
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      write_loop(2, 3'b111, 'h40, 'h60, 2);
      idle(2);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
